// File: rtl/freq_div_pkg.sv
// Shared constants and helpers for the programmable multi-channel clock divider.
package freq_div_pkg;

  // Smallest divisor that still yields a distinct high and low phase.
  localparam int unsigned DIV_MIN = 2;

  // Default divisor/counter width.
  localparam int unsigned W_DEF = 8;

  // Width of a channel index; a single channel still gets a 1-bit select.
  function automatic int unsigned ch_idx_w(input int unsigned ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/freq_div_ch.sv
// One divider channel: period counter, active/shadow divisor, posedge/negedge phase flops.
module freq_div_ch
  import freq_div_pkg::*;
#(
  parameter int unsigned     W       = W_DEF,
  parameter logic [W-1:0]    RST_DIV = W'(3)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         wr,
  input  logic [W-1:0] wr_div,
  output logic         div_out,
  output logic         tick,
  output logic         pend
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] act_q, act_d;
  logic [W-1:0] shd_q, shd_d;
  logic [W-1:0] next_div;
  logic         run_q;
  logic         p_q, p_d;
  logic         n_q;
  logic         tick_q, tick_d;
  logic         pend_q, pend_d;
  logic         boundary;

  // Next-state: a period boundary is a wrap, a start from idle, or a stopped channel.
  // Only at a boundary may the active divisor change, so no phase is ever cut short.
  always_comb begin
    act_d    = act_q;
    shd_d    = shd_q;
    pend_d   = pend_q;
    cnt_d    = '0;
    p_d      = 1'b0;
    tick_d   = 1'b0;
    // A write landing on the boundary edge is forwarded straight into the new period.
    next_div = wr ? wr_div : (pend_q ? shd_q : act_q);
    boundary = !en || !run_q || (cnt_q == act_q - W'(1));

    if (wr) begin
      shd_d = wr_div;
    end

    if (boundary) begin
      act_d  = next_div;
      pend_d = 1'b0;
    end else if (wr) begin
      pend_d = 1'b1;
    end

    if (en) begin
      if (boundary) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
      // High for the first floor(D/2) cycles of the period.
      p_d    = (cnt_d < (act_d >> 1));
      tick_d = (cnt_d == '0);
    end
  end

  // Posedge state: counter, divisors, phase flop and registered tick/pend.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      act_q  <= RST_DIV;
      shd_q  <= RST_DIV;
      run_q  <= 1'b0;
      p_q    <= 1'b0;
      tick_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      run_q  <= en;
      p_q    <= p_d;
      tick_q <= tick_d;
      pend_q <= pend_d;
    end
  end

  // Negedge stretch: carries the high phase half a cycle further, only for odd divisors.
  // Gating by oddness here keeps div_out a plain OR with no divisor-dependent mux glitch.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      n_q <= 1'b0;
    end else begin
      n_q <= p_q & act_q[0];
    end
  end

  assign div_out = p_q | n_q;
  assign tick    = tick_q;
  assign pend    = pend_q;

endmodule

// File: rtl/freq_div_prog.sv
// Multi-channel programmable 50%-duty clock divider with shadowed, glitch-free divisor writes.
module freq_div_prog
  import freq_div_pkg::*;
#(
  parameter int unsigned        CH      = 3,
  parameter int unsigned        W       = W_DEF,
  parameter logic [CH*W-1:0]    DEF_DIV = {8'd7, 8'd5, 8'd3},
  localparam int unsigned       CW      = ch_idx_w(CH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] en,
  input  logic          wr_en,
  input  logic [CW-1:0] wr_ch,
  input  logic [W-1:0]  wr_div,
  output logic [CH-1:0] div_out,
  output logic [CH-1:0] tick,
  output logic [CH-1:0] pend,
  output logic          wr_err
);

  logic          wr_ok;
  logic          wr_err_q;
  logic [CH-1:0] wr_sel;

  // Write decode: accept only an in-range channel and a divisor of at least DIV_MIN.
  always_comb begin
    wr_ok  = wr_en && ({1'b0, wr_ch} < (CW + 1)'(CH)) && (wr_div >= W'(DIV_MIN));
    wr_sel = '0;
    for (int i = 0; i < int'(CH); i++) begin
      wr_sel[i] = wr_ok && (wr_ch == CW'(i));
    end
  end

  // Rejected writes raise a single-cycle error pulse and touch nothing else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_en && !wr_ok;
    end
  end

  assign wr_err = wr_err_q;

  for (genvar g = 0; g < int'(CH); g++) begin : gen_ch
    freq_div_ch #(
      .W       (W),
      .RST_DIV (DEF_DIV[g*W +: W])
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en[g]),
      .wr      (wr_sel[g]),
      .wr_div  (wr_div),
      .div_out (div_out[g]),
      .tick    (tick[g]),
      .pend    (pend[g])
    );
  end

endmodule
